// File: rtl/gr_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : gr_apb_slave_regfile
// Description : APB slave with a bank of 32-bit registers, programmable wait
//               states and out-of-range / misalignment error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module gr_apb_slave_regfile #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_stb
);

    localparam int          c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [63:0] c_SPAN  = 64'(NUM_REGS) * 64'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;

    logic                 r_write;
    logic [31:0]          r_wdata;
    logic                 r_err;
    logic [c_IDX_W-1:0]   r_idx;
    logic [31:0]          r_regs [NUM_REGS];

    logic [63:0]          w_offset;
    logic                 w_dec_err;
    logic [c_IDX_W-1:0]   w_dec_idx;
    logic                 w_setup;

    logic                 w_cur_write;
    logic                 w_cur_err;
    logic [c_IDX_W-1:0]   w_cur_idx;

    assign w_setup   = psel & ~penable;
    assign w_offset  = paddr - BASE_ADDR;
    assign w_dec_err = (paddr < BASE_ADDR) | (w_offset >= c_SPAN) | (paddr[1:0] != 2'b00);
    assign w_dec_idx = w_offset[c_IDX_W+1:2];

    // With zero wait states DONE is entered straight from IDLE, before the
    // latches hold the transfer, so the live decode must be used there.
    always_comb begin
        w_cur_write = r_write;
        w_cur_err   = r_err;
        w_cur_idx   = r_idx;
        if (r_state == S_IDLE) begin
            w_cur_write = pwrite;
            w_cur_err   = w_dec_err;
            w_cur_idx   = w_dec_idx;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    if (WAIT_STATES == 0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (psel && penable) begin
                    if (r_cnt == 4'd0) begin
                        w_next = S_DONE;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            prdata  <= 32'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            wr_stb  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && w_setup) begin
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_err   <= w_dec_err;
                r_idx   <= w_dec_idx;
            end
            pready  <= (w_next == S_DONE);
            pslverr <= (w_next == S_DONE) & w_cur_err;
            prdata  <= (w_next == S_DONE && !w_cur_write && !w_cur_err) ? r_regs[w_cur_idx] : 32'd0;
            wr_stb  <= '0;
            // Commit happens on the edge leaving DONE so a reset there cancels it.
            if (r_state == S_DONE && r_write && !r_err) begin
                r_regs[r_idx] <= r_wdata;
                wr_stb[r_idx] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regq
            assign reg_q[32*gi +: 32] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gr_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_gr_apb_slave_regfile
// Description : Self-checking bench, one instance with 0 and one with 3 waits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gr_apb_slave_regfile;

    localparam logic [63:0] c_BASE = 64'h1000;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [1:0]   psel;
    logic [1:0]   penable;

    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [511:0] reg_q0, reg_q3;
    logic [15:0]  wr_stb0, wr_stb3;

    logic [31:0]  mdl [2][16];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    gr_apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(0), .BASE_ADDR(c_BASE)) dut0 (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .reg_q(reg_q0), .wr_stb(wr_stb0)
    );

    gr_apb_slave_regfile #(.NUM_REGS(16), .WAIT_STATES(3), .BASE_ADDR(c_BASE)) dut3 (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .reg_q(reg_q3), .wr_stb(wr_stb3)
    );

    function automatic logic       get_rdy(int w); return (w != 0) ? pready3 : pready0; endfunction
    function automatic logic       get_err(int w); return (w != 0) ? pslverr3 : pslverr0; endfunction
    function automatic logic [31:0] get_rd(int w); return (w != 0) ? prdata3 : prdata0; endfunction
    function automatic logic [15:0] get_stb(int w); return (w != 0) ? wr_stb3 : wr_stb0; endfunction
    function automatic logic [511:0] get_q(int w); return (w != 0) ? reg_q3 : reg_q0; endfunction

    function automatic logic [511:0] flat(int w);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = mdl[w][i];
        return r;
    endfunction

    function automatic bit exp_err(logic [63:0] a);
        return (a < c_BASE) || ((a - c_BASE) >= 64'd64) || (a[1:0] != 2'b00);
    endfunction

    task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer starting with its setup cycle now; returns in the
    // cycle after DONE with the bus idle, so a following call is back-to-back.
    task automatic xfer(int w, logic [63:0] a, logic wr, logic [31:0] d);
        int           ws;
        bit           e;
        int           idx;
        logic [63:0]  off;
        logic [31:0]  exp_rd;
        ws     = (w != 0) ? 3 : 0;
        e      = exp_err(a);
        off    = a - c_BASE;
        idx    = int'(off[5:2]);
        exp_rd = (!e && !wr) ? mdl[w][idx] : 32'd0;
        paddr = a; pwrite = wr; pwdata = d;
        psel[w] = 1'b1; penable[w] = 1'b0;
        step();
        penable[w] = 1'b1;
        paddr  = {$urandom, $urandom};
        pwdata = $urandom;
        for (int k = 0; k <= ws; k++) begin
            chk("pready_access", get_rdy(w), (k == ws));
            if (k == ws) begin
                chk("pslverr", get_err(w), e);
                if (!wr) chk("prdata", get_rd(w), exp_rd);
            end else begin
                chk("pslverr_wait", get_err(w), 0);
            end
            step();
        end
        psel[w] = 1'b0; penable[w] = 1'b0;
        if (wr && !e) mdl[w][idx] = d;
        chk("wr_stb", get_stb(w), (wr && !e) ? (16'd1 << idx) : 16'd0);
        chk("pready_after", get_rdy(w), 0);
        chk("reg_q", get_q(w), flat(w));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a;
        int          w;
        int          kind;

        for (int i = 0; i < 16; i++) begin mdl[0][i] = 32'd0; mdl[1][i] = 32'd0; end
        reset = 1'b1; psel = 2'b00; penable = 2'b00;
        paddr = 64'd0; pwrite = 1'b0; pwdata = 32'd0;
        repeat (2) step();
        chk("rst_pready0", pready0, 0);
        chk("rst_pready3", pready3, 0);
        chk("rst_pslverr", {pslverr0, pslverr3}, 0);
        chk("rst_prdata", {prdata0, prdata3}, 0);
        chk("rst_wr_stb", {wr_stb0, wr_stb3}, 0);
        chk("rst_reg_q0", reg_q0, 0);
        chk("rst_reg_q3", reg_q3, 0);
        reset = 1'b0;

        xfer(0, c_BASE + 64'd8, 1'b1, 32'hDEADBEEF);
        xfer(0, c_BASE + 64'd8, 1'b0, 32'h0);
        xfer(0, c_BASE + 64'h40, 1'b1, 32'h12345678);
        xfer(0, c_BASE + 64'd2, 1'b1, 32'h87654321);
        xfer(0, c_BASE - 64'd4, 1'b0, 32'h0);
        xfer(1, c_BASE, 1'b1, 32'hA5A50001);
        xfer(1, c_BASE, 1'b0, 32'h0);
        xfer(0, c_BASE + 64'd12, 1'b1, 32'h1);
        xfer(0, c_BASE + 64'd12, 1'b0, 32'h0);

        // penable with no preceding setup cycle must not start a transfer
        psel[0] = 1'b1; penable[0] = 1'b1; paddr = c_BASE; pwrite = 1'b1; pwdata = 32'hFFFF0000;
        repeat (3) begin
            step();
            chk("noset_pready", pready0, 0);
            chk("noset_stb", wr_stb0, 0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        step();
        chk("noset_reg_q", reg_q0, flat(0));

        // abort in the wait phase
        paddr = c_BASE + 64'd20; pwrite = 1'b1; pwdata = 32'h0BAD0BAD;
        psel[1] = 1'b1; penable[1] = 1'b0;
        step();
        penable[1] = 1'b1;
        step();
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) begin
            chk("abort_pready", pready3, 0);
            chk("abort_stb", wr_stb3, 0);
            step();
        end
        chk("abort_reg_q", reg_q3, flat(1));

        for (int n = 0; n < 60; n++) begin
            w    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            if (kind <= 5)      a = c_BASE + 64'(4 * $urandom_range(0, 15));
            else if (kind == 6) a = c_BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
            else if (kind == 7) a = c_BASE + 64'd64 + 64'(4 * $urandom_range(0, 255));
            else if (kind == 8) a = c_BASE - 64'(4 * $urandom_range(1, 100));
            else                a = {$urandom, $urandom};
            xfer(w, a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 1) == 1) step();
        end

        // reset in the middle of a waited write
        paddr = c_BASE + 64'd4; pwrite = 1'b1; pwdata = 32'hCAFEF00D;
        psel[1] = 1'b1; penable[1] = 1'b0;
        step();
        penable[1] = 1'b1;
        chk("rstmid_t1", pready3, 0);
        step();
        reset = 1'b1;
        chk("rstmid_t2", pready3, 0);
        step();
        reset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin mdl[0][i] = 32'd0; mdl[1][i] = 32'd0; end
        repeat (3) begin
            chk("rstmid_pready", pready3, 0);
            chk("rstmid_stb", wr_stb3, 0);
            step();
        end
        chk("rstmid_reg_q3", reg_q3, flat(1));
        chk("rstmid_reg_q0", reg_q0, flat(0));
        xfer(1, c_BASE + 64'd4, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gr_apb_slave_regfile.md
GR_APB_SLAVE_REGFILE -- requirements
Module: gr_apb_slave_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (1..256).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra access-phase cycles with pready low (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0, byte address of register 0.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port paddr  input  64  APB byte address.
REQ-007 SHALL have port psel  input  1  APB select.
REQ-008 SHALL have port penable  input  1  APB access phase.
REQ-009 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port pwdata  input  32  write data.
REQ-011 SHALL have port prdata  output  32  read data, registered.
REQ-012 SHALL have port pready  output  1  transfer completion, registered.
REQ-013 SHALL have port pslverr  output  1  transfer error, registered.
REQ-014 SHALL have port reg_q  output  NUM_REGS*32  register contents, register i at bits [32*i+31:32*i].
REQ-015 SHALL have port wr_stb  output  NUM_REGS  one-cycle pulse per register written.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-017 Setup cycle T0 = psel=1 & penable=0 while in IDLE; at the end of T0 SHALL latch paddr, pwrite, pwdata, decode result.
REQ-018 From IDLE on setup: WAIT_STATES=0 -> DONE; else -> WAIT with wait counter = WAIT_STATES-1.
REQ-019 In WAIT with psel=1 & penable=1: counter=0 -> DONE, else decrement, stay.
REQ-020 In WAIT, psel=0 or penable=0 (abort) SHALL return to IDLE with no write and no pready.
REQ-021 pready SHALL be 1 exactly in DONE, i.e. cycle T1+WAIT_STATES, for one cycle; DONE -> IDLE unconditionally.
REQ-022 Cycle after DONE SHALL be accepted as a new setup cycle (back-to-back, no idle gap required).
REQ-023 Decode: offset = paddr-BASE_ADDR; error if paddr<BASE_ADDR, offset>=NUM_REGS*4, or paddr[1:0]!=0; index = offset>>2.
REQ-024 pslverr SHALL equal latched error flag in DONE, 0 in all other cycles.
REQ-025 Read: prdata SHALL carry register[index] sampled at the edge entering DONE; 0 on error and in all non-DONE cycles.
REQ-026 Write, no error: register[index] SHALL take latched pwdata at the edge ending DONE; reg_q shows it from the next cycle.
REQ-027 wr_stb[index] SHALL be 1 for exactly the cycle after DONE of a successful write; all bits 0 otherwise.
REQ-028 Errored writes SHALL modify no register and pulse no wr_stb bit.
REQ-029 penable=1 seen in IDLE (no setup) SHALL be ignored.
REQ-030 pwdata/paddr changes after T0 SHALL NOT affect the transfer.

Reset
REQ-031 reset=1 at a rising edge SHALL force state IDLE, all registers 0, prdata 0, pready 0, pslverr 0, wr_stb 0.
REQ-032 reset during WAIT or DONE SHALL abort the transfer: no register write, no wr_stb pulse.
REQ-033 First setup cycle SHALL be accepted in the cycle after reset deasserts.

Verification
REQ-034 WAIT_STATES=0, write 32'hDEADBEEF to BASE_ADDR+8 -> pready=1 in T1, pslverr=0; reg_q[95:64]=32'hDEADBEEF and wr_stb=16'h0004 in T2.
REQ-035 Then read BASE_ADDR+8 -> prdata=32'hDEADBEEF, pready=1 in T1, wr_stb stays 0.
REQ-036 NUM_REGS=16: write BASE_ADDR+64'h40, then BASE_ADDR+2 -> pslverr=1 and pready=1 in T1 each, reg_q unchanged, wr_stb stays 0.
REQ-037 WAIT_STATES=3, read register 0 -> pready=0 in T1..T3, pready=1 and prdata valid in T4.
REQ-038 WAIT_STATES=3, write register 1, reset=1 in T2 -> pready never 1, register 1 = 0, wr_stb stays 0.
REQ-039 Back-to-back write reg 3 = 32'h1 then read reg 3 with setup right after DONE -> read returns 32'h1, two pready pulses separated by one setup cycle.
